switch_debouncer: RTL
=====================

Name: switch_debouncer

Overview:
- Conditions the raw slide-switch bank before it reaches the light/adder datapath.
- Each switch bit is synchronised into the clock domain, then debounced by a per-bit stability counter.
- Outputs are a clean, glitch-free switch vector that drives the top-level operand wiring, plus one-cycle rise/fall pulses for later sequential consumers.

Parameters:
- WIDTH, 8, number of switch bits handled; legal range 1..16.
- COUNT_MAX, 1000000, consecutive cycles a synchronised value must differ from the clean value before it is accepted. This is 10 ms at 100 MHz. Legal range 2..2^24; anything below 2 is an elaboration error.
- CNT_W, $clog2(COUNT_MAX), counter width; derived, never overridden.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- sw_raw  input  WIDTH  raw switch pins, asynchronous to clk.
- sw_clean  output  WIDTH  debounced switch vector, registered.
- sw_rise  output  WIDTH  one-cycle pulse per bit when sw_clean[i] goes 0->1.
- sw_fall  output  WIDTH  one-cycle pulse per bit when sw_clean[i] goes 1->0.
- any_change  output  1  OR of sw_rise and sw_fall, registered in the same cycle.

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous-to-clk deassert handled externally) clears all of the following to 0, effective immediately:
  - sync stage 1 and stage 2
  - all counters
  - sw_clean, sw_rise, sw_fall, any_change
- Synchroniser: two flops per bit. s1 <= sw_raw, then s2 <= s1. No logic between the stages.
- Per-bit state is two states, implicit in the counter:
  - STABLE: s2[i] == sw_clean[i]; counter[i] = 0.
  - PENDING: s2[i] != sw_clean[i]; counter[i] counts up.
- Each rising edge, per bit:
  - If s2 == sw_clean: counter <= 0. Any bounce back to the clean value fully restarts the qualification.
  - Else if counter == COUNT_MAX-1: sw_clean <= s2 and counter <= 0. sw_rise or sw_fall (by new value) is 1 for exactly this cycle.
  - Else: counter <= counter+1.
- sw_rise, sw_fall and any_change default to 0 every cycle not covered above. They never assert for two consecutive cycles on the same bit.
- Latency: take a clean step on sw_raw held steady, with the first edge that samples it numbered edge 1:
  - s1 updates at edge 1, s2 at edge 2.
  - Counting occurs at edges 3..COUNT_MAX+1.
  - sw_clean and the pulse update at edge COUNT_MAX+2.
- Glitch shorter than COUNT_MAX cycles after synchronisation: sw_clean unchanged, no pulse.
- Bits are fully independent. Simultaneous qualification on several bits updates them in the same cycle, with multiple pulse bits set and any_change = 1.
- Counter never exceeds COUNT_MAX-1, so there is no wrap.
- Reset mid-count: counter is discarded and sw_clean returns to 0. After release, a held-high switch requalifies from scratch, with the full COUNT_MAX+2 latency.
- No combinational path from sw_raw to any output.

Test Plan:
All scenarios use WIDTH=8 and COUNT_MAX=4, giving a step latency of 6 edges.
- Reset: hold rst_n=0 with sw_raw=8'hFF for 10 cycles -> all outputs 0; deassert -> sw_clean=8'hFF exactly 6 edges later, with sw_rise=8'hFF and any_change=1 for that one cycle.
- Clean step: sw_raw 8'h00->8'h05, held -> sw_clean=8'h05 at edge 6 with sw_rise=8'h05 for 1 cycle; sw_clean still 8'h00 at edge 5.
- Bounce: sw_raw[3] toggles 1,0,1,0 at 2-cycle intervals, then holds 1 -> no change during the toggling; sw_clean[3]=1 at edge 6 after the final transition; exactly one sw_rise[3] pulse.
- Fall plus independence: start at sw_clean=8'h0F; set sw_raw=8'hF0 in one cycle -> at edge 6 sw_clean=8'hF0, sw_rise=8'hF0, sw_fall=8'h0F, any_change=1 for 1 cycle, then all pulses 0.
- Reset mid-count: step sw_raw to 8'h01, assert rst_n at edge 4 for 2 cycles, release with sw_raw still 8'h01 -> sw_clean stays 0 through reset; sw_clean=8'h01 at edge 6 after release.
- Short glitch: sw_raw[7] high for 3 cycles, then low -> sw_clean[7]=0 throughout, sw_rise[7] and any_change never asserted.

Source files
------------

// File: rtl/switch_debouncer.sv
// switch_debouncer: two-flop synchroniser plus per-bit stability counter for
// a bank of mechanical slide switches. A new level is accepted only after the
// synchronised input has differed from the clean value for COUNT_MAX
// consecutive cycles. Any bounce back to the clean value restarts the count.
// Rise/fall pulses and any_change are registered alongside sw_clean.
module switch_debouncer #(
  parameter int WIDTH     = 8,
  parameter int COUNT_MAX = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             any_change
);

  localparam int              CNT_W    = $clog2(COUNT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // Out-of-range parameters are rejected at elaboration time.
  if ((COUNT_MAX < 2) || (COUNT_MAX > 16777216)) begin : g_count_max_err
    $error("switch_debouncer: COUNT_MAX must be in 2..2^24");
  end
  if ((WIDTH < 1) || (WIDTH > 16)) begin : g_width_err
    $error("switch_debouncer: WIDTH must be in 1..16");
  end

  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] sync2_r;
  logic [CNT_W-1:0] cnt_r     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt_s [WIDTH];
  logic [WIDTH-1:0] clean_nxt_s;
  logic [WIDTH-1:0] rise_nxt_s;
  logic [WIDTH-1:0] fall_nxt_s;
  logic             any_nxt_s;

  // Two-stage synchroniser; nothing sits between the stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= {WIDTH{1'b0}};
      sync2_r <= {WIDTH{1'b0}};
    end else begin
      sync1_r <= sw_raw;
      sync2_r <= sync1_r;
    end
  end

  // Per-bit qualification: clear on match, accept at the last count, else count.
  always_comb begin
    clean_nxt_s = sw_clean;
    rise_nxt_s  = {WIDTH{1'b0}};
    fall_nxt_s  = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt_s[i] = CNT_ZERO;
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_r[i] == sw_clean[i]) begin
        cnt_nxt_s[i] = CNT_ZERO;
      end else if (cnt_r[i] == CNT_LAST) begin
        cnt_nxt_s[i]   = CNT_ZERO;
        clean_nxt_s[i] = sync2_r[i];
        rise_nxt_s[i]  = sync2_r[i];
        fall_nxt_s[i]  = ~sync2_r[i];
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
      end
    end
    any_nxt_s = |(rise_nxt_s | fall_nxt_s);
  end

  // Stability counters; never exceed COUNT_MAX-1, so no wrap handling is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  // Registered clean vector and single-cycle edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_clean   <= {WIDTH{1'b0}};
      sw_rise    <= {WIDTH{1'b0}};
      sw_fall    <= {WIDTH{1'b0}};
      any_change <= 1'b0;
    end else begin
      sw_clean   <= clean_nxt_s;
      sw_rise    <= rise_nxt_s;
      sw_fall    <= fall_nxt_s;
      any_change <= any_nxt_s;
    end
  end

endmodule
